sha256_block_padder: RTL
========================

Name: sha256_block_padder

Overview:
- Upstream feeder for the SHA-256 hash core.
- Fetches a NUM_OF_WORDS-word message from word-addressed memory and applies SHA-256 padding: a 0x80000000 marker word, zero fill, and a 64-bit length.
- Hands the padded message to the core one 512-bit block at a time over a valid/ready handshake.
- The core no longer needs to read memory or pad.

Parameters:
- NUM_OF_WORDS, 20, message length in 32-bit words (1..200).
- MSG_SIZE, NUM_OF_WORDS*32, message length in bits; placed in the length field.

Ports:
- clk  in  1  system clock; also drives mem_clk
- reset_n  in  1  asynchronous active-low reset
- start  in  1  begin fetch/pad of one message; sampled only in IDLE
- message_addr  in  16  word address of message word 0; captured at start
- mem_clk  out  1  equals clk
- mem_we  out  1  constant 0; block never writes memory
- mem_addr  out  16  read address
- mem_read_data  in  32  memory data; valid one cycle after mem_addr is presented
- blk_valid  out  1  blk_data holds a complete padded block
- blk_ready  in  1  core accepts block
- blk_data  out  512  padded block; word 0 in [511:480], word 15 in [31:0]
- blk_last  out  1  qualifies blk_valid; current block is the final one
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after final block is accepted

Behaviour:
- Reset (asynchronous, any state, including mid-message): state=IDLE, blk_valid=0, blk_last=0, blk_data=0, busy=0, done=0, mem_addr=0, all counters=0.
- Block count: NUM_BLOCKS = (NUM_OF_WORDS+18)>>4. This is ceil((N+3)/16): one marker word plus two length words.
- Padded word at global index j (0..16*NUM_BLOCKS-1):
  - j < N: memory word at message_addr+j; 16-bit address wraps modulo 2^16.
  - j == N: 0x80000000.
  - j == 16*NUM_BLOCKS-2: 0x00000000 (length high word).
  - j == 16*NUM_BLOCKS-1: MSG_SIZE.
  - otherwise: 0.
- State IDLE: on start=1, capture message_addr, clear block index b and slot s, go to FETCH. start=0 stays in IDLE.
- State FETCH: one slot per cycle, s=0..15, global index j=16b+s.
  - j<N: drive mem_addr=message_addr+j; capture mem_read_data into buffer slot s on the following edge.
  - j>=N: write the pad value directly; mem_addr holds its last value.
  - After s=15, go to CAPTURE.
- State CAPTURE: one cycle; completes the pending memory capture. Next state PRESENT.
- Latency: blk_valid rises exactly 17 clock edges after the edge that leaves IDLE, or after the accepting handshake edge of the previous block.
- State PRESENT:
  - blk_valid=1; blk_last=1 when b==NUM_BLOCKS-1.
  - blk_data, blk_last stable while blk_valid && !blk_ready.
  - On blk_valid && blk_ready: blk_valid=0 the next cycle.
  - If not last: b++, s=0, go to FETCH.
  - If last: go to DONE.
- State DONE: done=1 for exactly one cycle, then IDLE. busy=0 in IDLE.
- blk_ready while blk_valid=0 is ignored. start while busy is ignored (no restart, no queuing).
- Single block buffer: no fetch overlaps a presented block.
- Counters: b is 8 bits, s is 4 bits; no wrap is possible within the NUM_OF_WORDS range.

Optional Feature:
- Macro: SHA256_PAD_BYTESWAP_EN.
- Defined: each memory word is byte-reversed before entering the buffer ({d[7:0],d[15:8],d[23:16],d[31:24]}), for little-endian message storage. Pad and length words are never swapped. Latency is unchanged.
- Undefined: memory words pass through unmodified.

Test Plan:
- N=20, message_addr=0x0000, mem[i]=0x01000000+i, blk_ready=1 → 2 blocks.
  - Block0: words 0x01000000..0x0100000F, blk_last=0.
  - Block1: words 0x01000010..0x01000013, then 0x80000000, words 5..14 = 0, word15=0x00000280, blk_last=1.
  - done pulses once; busy falls with it.
- N=13 → 1 block: words 0..12 = mem, word13=0x80000000, word14=0, word15=0x000001A0, blk_last=1.
- N=14 → 2 blocks:
  - Block0: word14=0x80000000, word15=0.
  - Block1: words 0..14 = 0, word15=0x000001C0.
- N=20, blk_ready held 0 for 10 cycles after blk_valid → blk_data/blk_last unchanged all 10 cycles; no mem_addr activity; block accepted on the first ready=1 edge.
- message_addr=0xFFFE, N=20 → mem_addr sequence 0xFFFE, 0xFFFF, 0x0000, ...; start pulsed during FETCH has no effect.
- reset_n asserted in block1 FETCH → all outputs 0 immediately. After release, a new start fetches block0 from scratch with the 17-edge latency.

Source files
------------

// File: rtl/sha256_block_padder.sv
// SHA-256 front end: fetches a NUM_OF_WORDS-word message, pads it and streams 512-bit blocks.
// Define SHA256_PAD_BYTESWAP_EN to byte-reverse memory words (little-endian message storage).
module sha256_block_padder #(
  parameter int unsigned NUM_OF_WORDS = 20,
  parameter int unsigned MSG_SIZE     = NUM_OF_WORDS * 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [15:0]  message_addr,
  output logic         mem_clk,
  output logic         mem_we,
  output logic [15:0]  mem_addr,
  input  logic [31:0]  mem_read_data,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [511:0] blk_data,
  output logic         blk_last,
  output logic         busy,
  output logic         done
);

  localparam int unsigned NUM_BLOCKS = (NUM_OF_WORDS + 18) >> 4;
  localparam logic [11:0] NumWords   = 12'(NUM_OF_WORDS);
  localparam logic [11:0] LastIdx    = 12'(16 * NUM_BLOCKS - 1);
  localparam logic [7:0]  LastBlk    = 8'(NUM_BLOCKS - 1);

  typedef enum logic [2:0] {StIdle, StFetch, StCapture, StPresent, StDone} state_e;

  state_e             state_q, state_d;
  logic [7:0]         b_q, b_d;
  logic [3:0]         s_q, s_d;
  logic [15:0]        base_q, base_d;
  logic [15:0]        mem_addr_q, mem_addr_d;
  logic               pend_q, pend_d;
  logic [3:0]         pend_slot_q, pend_slot_d;
  logic [0:15][31:0]  buf_q, buf_d;

  logic [11:0] j;
  logic [11:0] j_inc;
  logic [11:0] j_next_blk;
  logic [31:0] mem_word;
  logic [31:0] pad_word;

  assign j          = {b_q, s_q};
  assign j_inc      = j + 12'd1;
  assign j_next_blk = {b_q + 8'd1, 4'd0};

`ifdef SHA256_PAD_BYTESWAP_EN
  assign mem_word = {mem_read_data[7:0], mem_read_data[15:8],
                     mem_read_data[23:16], mem_read_data[31:24]};
`else
  assign mem_word = mem_read_data;
`endif

  // Only meaningful for j >= N: marker, length low word, or zero fill.
  always_comb begin
    pad_word = 32'h0000_0000;
    if (j == NumWords) begin
      pad_word = 32'h8000_0000;
    end else if (j == LastIdx) begin
      pad_word = 32'(MSG_SIZE);
    end
  end

  always_comb begin
    state_d     = state_q;
    b_d         = b_q;
    s_d         = s_q;
    base_d      = base_q;
    mem_addr_d  = mem_addr_q;
    pend_d      = 1'b0;
    pend_slot_d = pend_slot_q;
    buf_d       = buf_q;

    // Read data for the slot addressed last cycle arrives now.
    if (pend_q) begin
      buf_d[pend_slot_q] = mem_word;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          base_d     = message_addr;
          b_d        = 8'd0;
          s_d        = 4'd0;
          mem_addr_d = message_addr;
          state_d    = StFetch;
        end
      end
      StFetch: begin
        if (j < NumWords) begin
          pend_d      = 1'b1;
          pend_slot_d = s_q;
        end else begin
          buf_d[s_q] = pad_word;
        end
        if (s_q == 4'd15) begin
          state_d = StCapture;
        end else begin
          s_d = s_q + 4'd1;
          if (j_inc < NumWords) begin
            mem_addr_d = base_q + 16'(j_inc);
          end
        end
      end
      StCapture: begin
        state_d = StPresent;
      end
      StPresent: begin
        if (blk_ready) begin
          if (b_q == LastBlk) begin
            state_d = StDone;
          end else begin
            b_d     = b_q + 8'd1;
            s_d     = 4'd0;
            state_d = StFetch;
            if (j_next_blk < NumWords) begin
              mem_addr_d = base_q + 16'(j_next_blk);
            end
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      b_q         <= 8'd0;
      s_q         <= 4'd0;
      base_q      <= 16'd0;
      mem_addr_q  <= 16'd0;
      pend_q      <= 1'b0;
      pend_slot_q <= 4'd0;
      buf_q       <= '0;
    end else begin
      state_q     <= state_d;
      b_q         <= b_d;
      s_q         <= s_d;
      base_q      <= base_d;
      mem_addr_q  <= mem_addr_d;
      pend_q      <= pend_d;
      pend_slot_q <= pend_slot_d;
      buf_q       <= buf_d;
    end
  end

  assign mem_clk   = clk;
  assign mem_we    = 1'b0;
  assign mem_addr  = mem_addr_q;
  assign blk_valid = (state_q == StPresent);
  assign blk_last  = blk_valid && (b_q == LastBlk);
  assign blk_data  = buf_q;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);

endmodule
